// File: rtl/mux_seq_nch_if.sv
// Bus bundle for mux_seq_nch: control/data inputs and the registered output port.
//   master : drives inEn, inMode, inSel, inData; observes the outputs
//   slave  : the mux itself; consumes inputs, drives outData/outSel/outValid/outWrap
interface mux_seq_nch_if #(
  parameter int NCH   = 8,
  parameter int WIDTH = 1
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic                 inEn;
  logic                 inMode;
  logic [SEL_W-1:0]     inSel;
  logic [NCH*WIDTH-1:0] inData;
  logic [WIDTH-1:0]     outData;
  logic [SEL_W-1:0]     outSel;
  logic                 outValid;
  logic                 outWrap;

  modport master (
    output inEn, inMode, inSel, inData,
    input  outData, outSel, outValid, outWrap
  );

  modport slave (
    input  inEn, inMode, inSel, inData,
    output outData, outSel, outValid, outWrap
  );
endinterface

// File: rtl/mux_seq_nch.sv
// Registered N-channel multiplexer with manual select and round-robin scan.
//   inClk  : clock, rising edge
//   inRst  : synchronous active-high reset (overrides everything)
//   bus    : slave side of mux_seq_nch_if
//            inEn   - enable, low freezes state/counters and drops outValid
//            inMode - 0 manual (inSel picks channel), 1 round-robin scan
//            inSel  - manual channel index
//            inData - packed channels, channel i at [i*WIDTH +: WIDTH]
//            outData/outSel/outValid/outWrap - registered, one cycle latency
module mux_seq_nch #(
  parameter int NCH   = 8,
  parameter int WIDTH = 1,
  parameter int DWELL = 1
) (
  input logic          inClk,
  input logic          inRst,
  mux_seq_nch_if.slave bus
);
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW_W  = ($clog2(DWELL + 1) > 0) ? $clog2(DWELL + 1) : 1;

  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;

  state_t            state, stateNxt;
  logic [SEL_W-1:0]  chanCnt, chanNxt, curChan, selNxt;
  logic [DW_W-1:0]   dwellCnt, dwellNxt, curDwell;
  logic [WIDTH-1:0]  dataNxt;
  logic              validNxt, wrapNxt, lastDwell;
  logic [WIDTH-1:0]  chans [NCH];

  for (genvar i = 0; i < NCH; i++) begin : gUnpack
    assign chans[i] = bus.inData[i*WIDTH +: WIDTH];
  end

  // A scan entered from IDLE/MAN starts on channel 0 with a full dwell; the
  // entering edge already emits the first dwell cycle of channel 0.
  assign curChan   = (state == SCAN) ? chanCnt  : '0;
  assign curDwell  = (state == SCAN) ? dwellCnt : '0;
  assign lastDwell = (curDwell == DW_W'(DWELL - 1));

  always_comb begin
    stateNxt = state;
    chanNxt  = chanCnt;
    dwellNxt = dwellCnt;
    dataNxt  = bus.outData;
    selNxt   = bus.outSel;
    validNxt = 1'b0;
    wrapNxt  = 1'b0;
    if (bus.inEn) begin
      if (!bus.inMode) begin
        stateNxt = MAN;
        selNxt   = bus.inSel;
        if (int'(bus.inSel) < NCH) begin
          dataNxt  = chans[bus.inSel];
          validNxt = 1'b1;
        end else begin
          dataNxt  = '0;
        end
      end else begin
        stateNxt = SCAN;
        dataNxt  = chans[curChan];
        selNxt   = curChan;
        validNxt = 1'b1;
        wrapNxt  = lastDwell && (curChan == SEL_W'(NCH - 1));
        if (lastDwell) begin
          dwellNxt = '0;
          chanNxt  = (curChan == SEL_W'(NCH - 1)) ? '0 : curChan + 1'b1;
        end else begin
          dwellNxt = curDwell + 1'b1;
          chanNxt  = curChan;
        end
      end
    end
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state        <= IDLE;
      chanCnt      <= '0;
      dwellCnt     <= '0;
      bus.outData  <= '0;
      bus.outSel   <= '0;
      bus.outValid <= 1'b0;
      bus.outWrap  <= 1'b0;
    end else begin
      state        <= stateNxt;
      chanCnt      <= chanNxt;
      dwellCnt     <= dwellNxt;
      bus.outData  <= dataNxt;
      bus.outSel   <= selNxt;
      bus.outValid <= validNxt;
      bus.outWrap  <= wrapNxt;
    end
  end
endmodule

// File: tb/tb_mux_seq_nch.sv
// Bench for mux_seq_nch: four instances covering the different configurations,
// a vector table for single-cycle behaviour plus hand-written scan sequences.
module tb_mux_seq_nch;
  logic clk;
  logic inRst;
  int   checks;
  int   failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d=0: NCH=4 W=4 DWELL=1 ; d=1: NCH=8 W=1 DWELL=2
  // d=2: NCH=6 W=4 DWELL=3 ; d=3: NCH=2 W=1 DWELL=1
  mux_seq_nch_if #(.NCH(4), .WIDTH(4)) ifA ();
  mux_seq_nch_if #(.NCH(8), .WIDTH(1)) ifB ();
  mux_seq_nch_if #(.NCH(6), .WIDTH(4)) ifC ();
  mux_seq_nch_if #(.NCH(2), .WIDTH(1)) ifD ();

  mux_seq_nch #(.NCH(4), .WIDTH(4), .DWELL(1)) dutA (.inClk(clk), .inRst(inRst), .bus(ifA));
  mux_seq_nch #(.NCH(8), .WIDTH(1), .DWELL(2)) dutB (.inClk(clk), .inRst(inRst), .bus(ifB));
  mux_seq_nch #(.NCH(6), .WIDTH(4), .DWELL(3)) dutC (.inClk(clk), .inRst(inRst), .bus(ifC));
  mux_seq_nch #(.NCH(2), .WIDTH(1), .DWELL(1)) dutD (.inClk(clk), .inRst(inRst), .bus(ifD));

  typedef struct {
    int         d;
    logic       rst, en, mode;
    logic [7:0] sel;
    logic [23:0] data;
    logic [3:0] eD;
    logic [7:0] eS;
    logic       eV, eW;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic rst, en, mode, input logic [7:0] sel,
                              input logic [23:0] data, input logic [3:0] eD, input logic [7:0] eS,
                              input logic eV, eW, input string nm);
    vec_t v;
    v.d = d; v.rst = rst; v.en = en; v.mode = mode; v.sel = sel; v.data = data;
    v.eD = eD; v.eS = eS; v.eV = eV; v.eW = eW; v.nm = nm;
    return v;
  endfunction

  // Drive one instance's inputs, then sample 1 time unit past the next rising edge.
  task automatic step(input int d, input logic rst, en, mode, input logic [7:0] sel,
                      input logic [23:0] data);
    inRst = rst;
    case (d)
      0: begin ifA.inEn = en; ifA.inMode = mode; ifA.inSel = sel[1:0]; ifA.inData = data[15:0]; end
      1: begin ifB.inEn = en; ifB.inMode = mode; ifB.inSel = sel[2:0]; ifB.inData = data[7:0]; end
      2: begin ifC.inEn = en; ifC.inMode = mode; ifC.inSel = sel[2:0]; ifC.inData = data; end
      default: begin ifD.inEn = en; ifD.inMode = mode; ifD.inSel = sel[0]; ifD.inData = data[1:0]; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input logic [3:0] eD, input logic [7:0] eS,
                     input logic eV, eW);
    logic [3:0] aD;
    logic [7:0] aS;
    logic       aV, aW;
    case (d)
      0: begin aD = ifA.outData; aS = {6'b0, ifA.outSel}; aV = ifA.outValid; aW = ifA.outWrap; end
      1: begin aD = {3'b0, ifB.outData}; aS = {5'b0, ifB.outSel}; aV = ifB.outValid; aW = ifB.outWrap; end
      2: begin aD = ifC.outData; aS = {5'b0, ifC.outSel}; aV = ifC.outValid; aW = ifC.outWrap; end
      default: begin aD = {3'b0, ifD.outData}; aS = {7'b0, ifD.outSel}; aV = ifD.outValid; aW = ifD.outWrap; end
    endcase
    checks++;
    if ({aD, aS, aV, aW} !== {eD, eS, eV, eW}) begin
      failures++;
      $display("FAIL %s: got data=%h sel=%0d valid=%b wrap=%b, want data=%h sel=%0d valid=%b wrap=%b",
               nm, aD, aS, aV, aW, eD, eS, eV, eW);
    end
  endtask

  localparam logic [23:0] DA = 24'h00F0A5;   // ch0..3 = 5,A,0,F
  localparam logic [23:0] DB = 24'h0000A6;   // 8'b1010_0110
  localparam logic [23:0] DC = 24'hA98765;   // ch0..5 = 5,6,7,8,9,A
  localparam logic [23:0] DD = 24'h000002;   // 2'b10

  int expB[16] = '{0,0,1,1,1,1,0,0,0,0,1,1,0,0,1,1};

  initial begin
    checks = 0;
    failures = 0;
    inRst = 1'b1;
    ifA.inEn = 0; ifA.inMode = 0; ifA.inSel = '0; ifA.inData = '0;
    ifB.inEn = 0; ifB.inMode = 0; ifB.inSel = '0; ifB.inData = '0;
    ifC.inEn = 0; ifC.inMode = 0; ifC.inSel = '0; ifC.inData = '0;
    ifD.inEn = 0; ifD.inMode = 0; ifD.inSel = '0; ifD.inData = '0;

    // Manual select on the 4x4 instance: MUX414 truth table with one cycle latency.
    vecs.push_back(mk(0, 1, 1, 1, 0, DA, 4'h0, 0, 0, 0, "A reset"));
    vecs.push_back(mk(0, 0, 1, 0, 0, DA, 4'h5, 0, 1, 0, "A man sel0"));
    vecs.push_back(mk(0, 0, 1, 0, 1, DA, 4'hA, 1, 1, 0, "A man sel1"));
    vecs.push_back(mk(0, 0, 1, 0, 2, DA, 4'h0, 2, 1, 0, "A man sel2"));
    vecs.push_back(mk(0, 0, 1, 0, 3, DA, 4'hF, 3, 1, 0, "A man sel3"));
    vecs.push_back(mk(0, 0, 0, 0, 1, 24'h0, 4'hF, 3, 0, 0, "A disabled hold"));
    // Out-of-range manual select on the 6-channel instance.
    vecs.push_back(mk(2, 1, 0, 0, 0, DC, 4'h0, 0, 0, 0, "C reset"));
    vecs.push_back(mk(2, 0, 1, 0, 7, DC, 4'h0, 7, 0, 0, "C man sel7 invalid"));
    vecs.push_back(mk(2, 0, 1, 0, 5, DC, 4'hA, 5, 1, 0, "C man sel5"));
    vecs.push_back(mk(2, 0, 1, 0, 0, DC, 4'h5, 0, 1, 0, "C man sel0"));
    vecs.push_back(mk(2, 0, 0, 0, 3, DC, 4'h5, 0, 0, 0, "C disabled hold"));
    // Two channels, DWELL=1: alternate every cycle, wrap on every channel-1 cycle.
    vecs.push_back(mk(3, 1, 0, 0, 0, DD, 4'h0, 0, 0, 0, "D reset"));
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(3, 0, 1, 1, 0, DD, (k % 2 == 0) ? 4'h1 : 4'h0,
                        (k % 2 == 0) ? 8'd1 : 8'd0, 1, (k % 2 == 0), "D scan"));

    foreach (vecs[i]) begin
      step(vecs[i].d, vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].data);
      chk(vecs[i].nm, vecs[i].d, vecs[i].eD, vecs[i].eS, vecs[i].eV, vecs[i].eW);
    end

    // Eight channels, DWELL=2, full sweep from IDLE.
    step(1, 1, 0, 0, 0, DB);
    chk("B reset", 1, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 1, 1, 0, DB);
      chk("B sweep", 1, 4'(expB[k]), 8'(k / 2), 1, (k == 15));
    end
    step(1, 0, 1, 1, 0, DB);
    chk("B after wrap", 1, 0, 0, 1, 0);

    // Six channels, DWELL=3: pause mid-dwell on channel 2.
    step(2, 1, 0, 0, 0, DC);
    chk("C reset2", 2, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(2, 0, 1, 1, 0, DC);
      chk("C scan pre-pause", 2, 4'(5 + k / 3), 8'(k / 3), 1, 0);
    end
    for (int k = 0; k < 5; k++) begin
      step(2, 0, 0, 1, 0, 24'h0);
      chk("C paused", 2, 4'h7, 2, 0, 0);
    end
    step(2, 0, 1, 1, 0, DC);
    chk("C resume ch2", 2, 4'h7, 2, 1, 0);
    step(2, 0, 1, 1, 0, DC);
    chk("C resume ch3", 2, 4'h8, 3, 1, 0);
    for (int k = 0; k < 6; k++) begin
      step(2, 0, 1, 1, 0, DC);
      chk("C scan to ch5", 2, (k < 2) ? 4'h8 : (k < 5) ? 4'h9 : 4'hA,
          (k < 2) ? 8'd3 : (k < 5) ? 8'd4 : 8'd5, 1, 0);
    end
    // Mid-dwell on channel 5: one manual cycle, then scan restarts at channel 0.
    step(2, 0, 1, 0, 1, DC);
    chk("C man interrupt", 2, 4'h6, 1, 1, 0);
    for (int k = 0; k < 18; k++) begin
      step(2, 0, 1, 1, 0, DC);
      chk("C rescan", 2, 4'(5 + k / 3), 8'(k / 3), 1, (k == 17));
    end
    // Reset mid-scan.
    step(2, 0, 1, 1, 0, DC);
    chk("C post-wrap ch0", 2, 4'h5, 0, 1, 0);
    step(2, 1, 1, 1, 0, DC);
    chk("C reset mid-scan", 2, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(2, 0, 1, 1, 0, DC);
      chk("C scan after reset", 2, 4'(5 + k / 3), 8'(k / 3), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_seq_nch.md
Name: mux_seq_nch

Overview:
- Parametrised, registered N-channel multiplexer. Successor to the fixed combinational MUX211/MUX414/MUX811 family.
- Adds a manual-select mode and an automatic round-robin scan mode with a programmable dwell time per channel.
- Provides a registered output with valid, channel tag and end-of-sweep wrap flag.
- Used in the baseband datapath to time-division channels onto one downstream bus, and as a drop-in registered replacement for the fixed muxes.

Parameters:
- NCH, 8, number of input channels (2..256, need not be a power of 2)
- WIDTH, 1, bits per channel
- DWELL, 1, output cycles spent on each channel in scan mode (1..65535)
- SEL_W, $clog2(NCH) (minimum 1), select/index width (derived, not overridden)

Ports:
- inClk  in  1  clock, all logic on rising edge
- inRst  in  1  synchronous active-high reset
- inEn  in  1  enable; when low, state and counters freeze
- inMode  in  1  0 = manual select, 1 = round-robin scan
- inSel  in  SEL_W  channel index used in manual mode
- inData  in  NCH*WIDTH  packed channels; channel i = inData[i*WIDTH +: WIDTH]
- outData  out  WIDTH  registered selected channel data
- outSel  out  SEL_W  index of the channel currently on outData
- outValid  out  1  outData/outSel are meaningful this cycle
- outWrap  out  1  single-cycle pulse on the last dwell cycle of channel NCH-1 in scan mode

Behaviour:
- Reset: one clock, synchronous, active-high; inClk and inRst as above. While inRst is high at an edge, all outputs go to 0, state goes to IDLE, chanCnt=0, dwellCnt=0. inRst overrides inEn and inMode.
- States: IDLE, MAN, SCAN. Evaluated each edge with inRst=0:
  - inEn=0 -> state unchanged; counters frozen; outData/outSel hold last value; outValid=0; outWrap=0.
  - inEn=1, inMode=0 -> MAN.
  - inEn=1, inMode=1 -> SCAN. Entering from IDLE or MAN clears chanCnt and dwellCnt to 0. Resuming SCAN after inEn=0 does not clear them.
- Latency: 1 cycle. Outputs at edge t+1 reflect inputs sampled at edge t. There is no combinational path from input to output.
- MAN, on each enabled edge:
  - inSel < NCH -> outData = channel inSel, outSel = inSel, outValid = 1.
  - inSel >= NCH -> outData = 0, outSel = inSel, outValid = 0.
  - outWrap = 0 in MAN.
- SCAN, on each enabled edge:
  - outData = channel chanCnt (sampled live, not latched at dwell start); outSel = chanCnt; outValid = 1.
  - If dwellCnt == DWELL-1: dwellCnt <= 0, and chanCnt <= (chanCnt == NCH-1) ? 0 : chanCnt+1. Otherwise dwellCnt <= dwellCnt+1.
  - outWrap = 1 on the output cycle where chanCnt == NCH-1 and dwellCnt == DWELL-1; else 0.
  - chanCnt never takes values >= NCH.
- Mode switch:
  - SCAN -> MAN takes effect on the same edge, with no drain of the remaining dwell.
  - MAN -> SCAN restarts at channel 0 with a full dwell.
  - A toggle in consecutive cycles is legal; each cycle follows the rules above.
- inSel is ignored in SCAN. inData is don't-care while inEn=0.
- Reset mid-scan: next output cycle after reset release with inEn=1, inMode=1 shows channel 0.
- DWELL=1: a new channel every enabled cycle; outWrap every NCH cycles.
- Width rules: dwellCnt is $clog2(DWELL+1) bits, minimum 1. No arithmetic overflow is possible by construction.

Test Plan:
1. NCH=4, WIDTH=4, inData=16'hF0A5, inEn=1, inMode=0, inSel stepping 0,1,2,3 one per cycle -> outData 5,A,0,F one cycle later each; outSel 0..3; outValid=1; outWrap=0. This reproduces the MUX414 truth table with 1-cycle latency.
2. NCH=8, WIDTH=1, DWELL=2, inData=8'b1010_0110, inMode=1 from IDLE for 16 cycles -> outSel 0,0,1,1,…,7,7; outData 0,0,1,1,1,1,0,0,0,0,1,1,0,0,1,1; outWrap=1 only on cycle 16; cycle 17 outSel=0.
3. NCH=6, manual, inSel=7 -> outValid=0, outData=0, outSel=7. Then inSel=5 -> outValid=1 and channel 5 data next cycle.
4. Scan DWELL=3 with inEn dropped at chanCnt=2/dwellCnt=1 for 5 cycles -> outValid=0 and outputs held for those cycles. On re-enable: one more channel-2 cycle, then channel 3.
5. Scan at chanCnt=5, switch to manual inSel=1 for one cycle, then back to scan -> outputs: ch1 (manual) then ch0 with full dwell. Separately, inRst=1 for one cycle mid-scan -> all outputs 0 next cycle, then scan restarts at ch0.
6. NCH=2, WIDTH=1, DWELL=1, continuous scan for 10 cycles -> outSel alternates 0,1; outWrap pulses on cycles 2,4,6,8,10; inData=2'b10 gives outData 0,1,0,1,….
